div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 23 ++
 rtl/div_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: register types, FSM encoding and
// handshake constants.
package div_unit_pkg;

  typedef logic [31:0] Reg_t;
  typedef logic [63:0] DoubleReg_t;

  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_e;

  localparam logic RstEnable         = 1'b1;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [5:0] DivIters = 6'd32;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, 32-bit signed/unsigned operands, one quotient bit per
// cycle. Result is {remainder, quotient} and is held until the requester drops start_i.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       signed_div_i,
  input  Reg_t       opdata1_i,
  input  Reg_t       opdata2_i,
  input  logic       start_i,
  input  logic       annul_i,
  output DoubleReg_t result_o,
  output logic       ready_o
);

  div_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  Reg_t        divisor_q, divisor_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  DoubleReg_t  result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] diff;
  Reg_t        op1_mag, op2_mag;
  Reg_t        quot, rem;

  assign diff    = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
  assign op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    quot       = neg_quot_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    rem        = neg_rem_q ? (~work_q[64:33] + 32'd1) : work_q[64:33];

    unique case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          work_d     = {32'b0, op1_mag, 1'b0};
          divisor_d  = op2_mag;
          neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d  = signed_div_i && opdata1_i[31];
          cnt_d      = 6'd0;
          state_d    = (opdata2_i == 32'd0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        // Two cycles here so divide-by-zero reports two edges after acceptance.
        if (annul_i) begin
          state_d = DivFree;
          cnt_d   = 6'd0;
        end else if (cnt_q == 6'd0) begin
          cnt_d = 6'd1;
        end else begin
          state_d  = DivEnd;
          cnt_d    = 6'd0;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
          cnt_d   = 6'd0;
        end else if (cnt_q != DivIters) begin
          if (diff[32]) begin
            work_d = {work_q[63:0], 1'b0};
          end else begin
            work_d = {diff[31:0], work_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {rem, quot};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
          cnt_d    = 6'd0;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q    <= DivFree;
      cnt_q      <= 6'd0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
